aurora_tx_framer: RTL and testbench

- Parametrised TX framer for the Aurora channel.
- Accepts AXI-stream beats of LANES 16-bit words with valid/ready backpressure.
- Wraps each frame in SCP/ECP ordered sets and fills gaps with IDLE.
- Inserts periodic clock-compensation (CC) sequences.
- Runtime single_lane mode serialises each beat onto lane 0.
- Sits between the user AXI interface and the per-lane 8b/10b encoders.

---
 rtl/aurora_pkg.sv | 24 ++
 rtl/aurora_cc_timer.sv | 41 ++++
 rtl/aurora_tx_framer.sv | 209 ++++++++++++++++++++
 tb/tb_aurora_tx_framer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_pkg.sv
// Shared types for the Aurora TX path: per-lane ordered-set codes and framer states.
package aurora_pkg;

    localparam int unsigned LANE_W_DEFAULT = 16;
    localparam int unsigned OS_W           = 3;

    typedef enum logic [OS_W-1:0] {
        OS_IDLE = 3'd0,
        OS_SCP  = 3'd1,
        OS_ECP  = 3'd2,
        OS_DATA = 3'd3,
        OS_CC   = 3'd4
    } ordered_sets_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SCP  = 3'd1,
        ST_DATA = 3'd2,
        ST_SER  = 3'd3,
        ST_ECP  = 3'd4,
        ST_CC   = 3'd5
    } framer_state_e;

endpackage

// File: rtl/aurora_cc_timer.sv
// Clock-compensation interval timer; the first CC cycle counts as cycle 0 of the next period.
module aurora_cc_timer
#(
    parameter int unsigned CC_PERIOD = 5000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic cc_due
);

    localparam int unsigned CNT_W = $clog2(CC_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CC_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;

    always_comb begin
        cnt_n = cnt_q;
        if (restart) begin
            cnt_n = CNT_W'(1);
        end else if (cnt_q != CNT_LAST) begin
            cnt_n = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            cc_due <= 1'b0;
        end else if (!en) begin
            cnt_q  <= '0;
            cc_due <= 1'b0;
        end else begin
            cnt_q  <= cnt_n;
            cc_due <= (cnt_n == CNT_LAST);
        end
    end

endmodule

// File: rtl/aurora_tx_framer.sv
// Aurora TX framer: wraps AXI-stream frames in SCP/ECP, fills gaps with IDLE,
// inserts periodic CC and optionally serialises each beat onto lane 0.
module aurora_tx_framer
    import aurora_pkg::*;
#(
    parameter int unsigned LANES     = 2,
    parameter int unsigned LANE_W    = LANE_W_DEFAULT,
    parameter int unsigned CC_PERIOD = 5000,
    parameter int unsigned CC_LEN    = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      channel_up,
    input  logic                      single_lane,
    input  logic                      axi_valid,
    output logic                      axi_ready,
    input  logic                      axi_last,
    input  logic [LANES-1:0]          axi_keep,
    input  logic [LANES*LANE_W-1:0]   axi_data,
    output ordered_sets_e [LANES-1:0] lane_os,
    output logic [LANES*LANE_W-1:0]   lane_data
);

    localparam int unsigned DATA_W = LANES * LANE_W;
    localparam int unsigned IDX_W  = $clog2(LANES + 1);
    localparam int unsigned CCC_W  = $clog2(CC_LEN + 1);

    framer_state_e            state_q, state_d;
    logic                     mode_sl_q, mode_sl_d;
    logic                     ret_data_q, ret_data_d;
    logic [CCC_W-1:0]         cc_cnt_q, cc_cnt_d;
    logic [DATA_W-1:0]        buf_q, buf_d;
    logic [LANES-1:0]         keep_q, keep_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     last_q, last_d;
    ordered_sets_e [LANES-1:0] lane_os_d;
    logic [DATA_W-1:0]        lane_data_d;

    logic cc_due;
    logic cc_restart;
    logic accept;
    logic more_beat;
    logic more_ser;
    logic keep_contig;

    aurora_cc_timer #(
        .CC_PERIOD (CC_PERIOD)
    ) u_cc_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (channel_up),
        .restart (cc_restart),
        .cc_due  (cc_due)
    );

    // Ready depends on registered state only, never on axi_valid.
    assign axi_ready = (state_q == ST_DATA) && !cc_due;
    assign accept    = axi_valid && axi_ready;

    assign cc_restart = channel_up && (state_q == ST_CC) && (cc_cnt_q == '0);

    // Contiguous-from-bit-0 keep masks have no set bit above a clear one.
    assign keep_contig = ((axi_keep + LANES'(1)) & axi_keep) == LANES'(0);

    always_comb begin
        more_beat = 1'b0;
        for (int i = 1; i < LANES; i++) begin
            if (axi_keep[i]) more_beat = 1'b1;
        end
        more_ser = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if ((i > int'(idx_q)) && keep_q[i]) more_ser = 1'b1;
        end
    end

    // Next state and next output words; outputs lag the state by one cycle.
    always_comb begin
        state_d     = state_q;
        mode_sl_d   = mode_sl_q;
        ret_data_d  = ret_data_q;
        cc_cnt_d    = cc_cnt_q;
        buf_d       = buf_q;
        keep_d      = keep_q;
        idx_d       = idx_q;
        last_d      = last_q;
        lane_data_d = '0;
        for (int i = 0; i < LANES; i++) lane_os_d[i] = OS_IDLE;

        if (!channel_up) begin
            state_d  = ST_IDLE;
            cc_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cc_due) begin
                        state_d    = ST_CC;
                        ret_data_d = 1'b0;
                    end else if (axi_valid) begin
                        state_d   = ST_SCP;
                        mode_sl_d = single_lane;
                    end
                end
                ST_SCP: begin
                    lane_os_d[0] = OS_SCP;
                    if (cc_due) begin
                        state_d    = ST_CC;
                        ret_data_d = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        if (mode_sl_q) begin
                            if (axi_keep[0]) begin
                                lane_os_d[0]             = OS_DATA;
                                lane_data_d[LANE_W-1:0]  = axi_data[LANE_W-1:0];
                            end
                            if (more_beat) begin
                                state_d = ST_SER;
                                buf_d   = axi_data;
                                keep_d  = axi_keep;
                                idx_d   = IDX_W'(1);
                                last_d  = axi_last;
                            end else if (axi_last) begin
                                state_d = ST_ECP;
                            end
                        end else begin
                            for (int i = 0; i < LANES; i++) begin
                                if (axi_keep[i]) begin
                                    lane_os_d[i]                    = OS_DATA;
                                    lane_data_d[i*LANE_W +: LANE_W] = axi_data[i*LANE_W +: LANE_W];
                                end
                            end
                            if (axi_last) state_d = ST_ECP;
                        end
                    end else if (cc_due) begin
                        state_d    = ST_CC;
                        ret_data_d = 1'b1;
                    end
                end
                ST_SER: begin
                    lane_os_d[0]            = OS_DATA;
                    lane_data_d[LANE_W-1:0] = buf_q[int'(idx_q)*LANE_W +: LANE_W];
                    if (more_ser) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        state_d = last_q ? ST_ECP : ST_DATA;
                    end
                end
                ST_ECP: begin
                    lane_os_d[0] = OS_ECP;
                    if (cc_due) begin
                        state_d    = ST_CC;
                        ret_data_d = 1'b0;
                    end else if (axi_valid) begin
                        state_d   = ST_SCP;
                        mode_sl_d = single_lane;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CC: begin
                    for (int i = 0; i < LANES; i++) lane_os_d[i] = OS_CC;
                    if (cc_cnt_q == CCC_W'(CC_LEN - 1)) begin
                        cc_cnt_d = '0;
                        state_d  = ret_data_q ? ST_DATA : ST_IDLE;
                    end else begin
                        cc_cnt_d = cc_cnt_q + CCC_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_sl_q  <= 1'b0;
            ret_data_q <= 1'b0;
            cc_cnt_q   <= '0;
            buf_q      <= '0;
            keep_q     <= '0;
            idx_q      <= '0;
            last_q     <= 1'b0;
            lane_data  <= '0;
            for (int i = 0; i < LANES; i++) lane_os[i] <= OS_IDLE;
        end else begin
            state_q    <= state_d;
            mode_sl_q  <= mode_sl_d;
            ret_data_q <= ret_data_d;
            cc_cnt_q   <= cc_cnt_d;
            buf_q      <= buf_d;
            keep_q     <= keep_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            lane_data  <= lane_data_d;
            lane_os    <= lane_os_d;
        end
    end

    // Upstream must present keep masks contiguous from lane 0.
    a_keep_contig: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> keep_contig);

endmodule

// File: tb/tb_aurora_tx_framer.sv
// Self-checking bench for aurora_tx_framer: directed frames plus random traffic vs a stream model.
module tb_aurora_tx_framer;
    import aurora_pkg::*;

    localparam int unsigned LANES     = 2;
    localparam int unsigned LANE_W    = 16;
    localparam int unsigned CC_PERIOD = 32;
    localparam int unsigned CC_LEN    = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      channel_up;
    logic                      single_lane;
    logic                      axi_valid;
    logic                      axi_ready;
    logic                      axi_last;
    logic [LANES-1:0]          axi_keep;
    logic [LANES*LANE_W-1:0]   axi_data;
    ordered_sets_e [LANES-1:0] lane_os;
    logic [LANES*LANE_W-1:0]   lane_data;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        ordered_sets_e os0;
        ordered_sets_e os1;
        logic [15:0]   d0;
        logic [15:0]   d1;
        logic          rdy;
    } tok_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  keep;
        logic        last;
    } beat_t;

    tok_t        log_q[$];
    tok_t        exp_tok[$];
    beat_t       tx_q[$];
    logic [15:0] exp_words[$];
    logic        logging = 1'b0;

    aurora_tx_framer #(
        .LANES     (LANES),
        .LANE_W    (LANE_W),
        .CC_PERIOD (CC_PERIOD),
        .CC_LEN    (CC_LEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .channel_up  (channel_up),
        .single_lane (single_lane),
        .axi_valid   (axi_valid),
        .axi_ready   (axi_ready),
        .axi_last    (axi_last),
        .axi_keep    (axi_keep),
        .axi_data    (axi_data),
        .lane_os     (lane_os),
        .lane_data   (lane_data)
    );

    always #5 clk = ~clk;

    // Output trace, one token per cycle, sampled mid-cycle.
    always @(negedge clk) begin : mon
        tok_t t;
        if (logging) begin
            t.os0 = lane_os[0];
            t.os1 = lane_os[1];
            t.d0  = lane_data[15:0];
            t.d1  = lane_data[31:16];
            t.rdy = axi_ready;
            log_q.push_back(t);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic tok_t mk(input ordered_sets_e a, input logic [15:0] da,
                                input ordered_sets_e b, input logic [15:0] db);
        tok_t t;
        t.os0 = a; t.os1 = b; t.d0 = da; t.d1 = db; t.rdy = 1'b0;
        return t;
    endfunction

    function automatic logic [63:0] key(input tok_t t);
        return 64'({t.os0, t.os1, t.d0, t.d1});
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [1:0] k, input logic l);
        bit done;
        done      = 1'b0;
        axi_valid = 1'b1;
        axi_data  = d;
        axi_keep  = k;
        axi_last  = l;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            done = axi_ready;
            @(posedge clk);
            #1;
        end
        if (!done) chk("handshake_timeout", 64'(0), 64'(1));
    endtask

    task automatic send_queue();
        beat_t b;
        while (tx_q.size() > 0) begin
            b = tx_q.pop_front();
            send_beat(b.data, b.keep, b.last);
        end
        axi_valid = 1'b0;
        axi_last  = 1'b0;
        axi_keep  = 2'b00;
    endtask

    task automatic wait_cc_end();
        int c;
        c = 0;
        while (lane_os[0] != OS_CC && c < 100) begin tick(1); c++; end
        while (lane_os[0] == OS_CC && c < 120) begin tick(1); c++; end
        if (c >= 100) chk("cc_wait_timeout", 64'(c), 64'(0));
    endtask

    // Compares the trace from its first SCP onwards with exp_tok.
    task automatic expect_seq(input string tag, output int base);
        base = -1;
        for (int j = 0; j < log_q.size() && base < 0; j++) begin
            if (log_q[j].os0 == OS_SCP) base = j;
        end
        if (base < 0) begin
            chk({tag, "_no_scp"}, 64'(0), 64'(1));
            base = 0;
        end else begin
            for (int k = 0; k < exp_tok.size(); k++) begin
                if (base + k < log_q.size())
                    chk($sformatf("%s_tok%0d", tag, k), key(log_q[base+k]), key(exp_tok[k]));
                else
                    chk($sformatf("%s_short%0d", tag, k), 64'(0), 64'(1));
            end
        end
    endtask

    // Scoreboard: kept words in lane order, one SCP/ECP per frame, lane 1 idle in single-lane mode.
    task automatic check_words(input string tag, input int nframes, input bit sl);
        logic [15:0] got[$];
        int nscp, necp, bad_l1;
        nscp = 0; necp = 0; bad_l1 = 0;
        foreach (log_q[j]) begin
            if (log_q[j].os0 == OS_DATA) got.push_back(log_q[j].d0);
            if (log_q[j].os1 == OS_DATA) got.push_back(log_q[j].d1);
            if (log_q[j].os0 == OS_SCP) nscp++;
            if (log_q[j].os0 == OS_ECP) necp++;
            if (sl && !(log_q[j].os1 == OS_IDLE || (log_q[j].os1 == OS_CC && log_q[j].os0 == OS_CC)))
                bad_l1++;
        end
        chk({tag, "_word_count"}, 64'(got.size()), 64'(exp_words.size()));
        for (int k = 0; k < exp_words.size() && k < got.size(); k++)
            chk($sformatf("%s_word%0d", tag, k), 64'(got[k]), 64'(exp_words[k]));
        chk({tag, "_scp_count"}, 64'(nscp), 64'(nframes));
        chk({tag, "_ecp_count"}, 64'(necp), 64'(nframes));
        if (sl) chk({tag, "_lane1_idle"}, 64'(bad_l1), 64'(0));
    endtask

    // CC runs: both lanes, CC_LEN long, CC_PERIOD apart, ready low in the cycles producing them.
    task automatic check_cc(input string tag);
        int j, s, prev, runs;
        j = 0; prev = -1; runs = 0;
        while (j < log_q.size()) begin
            if (log_q[j].os0 == OS_CC) begin
                s = j;
                while (j < log_q.size() && log_q[j].os0 == OS_CC) begin
                    chk({tag, "_cc_lane1"}, 64'(log_q[j].os1), 64'(OS_CC));
                    if (j > 0) chk({tag, "_cc_ready"}, 64'(log_q[j-1].rdy), 64'(0));
                    j++;
                end
                if (j < log_q.size()) begin
                    chk({tag, "_cc_len"}, 64'(j - s), 64'(CC_LEN));
                    if (prev >= 0) chk({tag, "_cc_spacing"}, 64'(s - prev), 64'(CC_PERIOD));
                    prev = s;
                    runs++;
                end
            end else begin
                j++;
            end
        end
        chk({tag, "_cc_runs_seen"}, 64'(runs >= 2), 64'(1));
    endtask

    task automatic gen_frames(input int nframes);
        beat_t bt;
        int nb, kk;
        for (int f = 0; f < nframes; f++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                bt.data = $urandom;
                bt.last = (b == nb - 1);
                bt.keep = 2'b11;
                if (bt.last) begin
                    kk = $urandom_range(0, 4);
                    bt.keep = (kk == 0) ? 2'b00 : (kk == 1) ? 2'b01 : 2'b11;
                end
                tx_q.push_back(bt);
                if (bt.keep[0]) exp_words.push_back(bt.data[15:0]);
                if (bt.keep[1]) exp_words.push_back(bt.data[31:16]);
            end
        end
    endtask

    task automatic push_beat(input logic [31:0] d, input logic [1:0] k, input logic l);
        beat_t bt;
        bt.data = d; bt.keep = k; bt.last = l;
        tx_q.push_back(bt);
    endtask

    initial begin
        int base;
        rst_n       = 1'b0;
        channel_up  = 1'b0;
        single_lane = 1'b0;
        axi_valid   = 1'b0;
        axi_last    = 1'b0;
        axi_keep    = 2'b00;
        axi_data    = '0;

        // Reset state
        #22;
        chk("rst_os0", 64'(lane_os[0]), 64'(OS_IDLE));
        chk("rst_os1", 64'(lane_os[1]), 64'(OS_IDLE));
        chk("rst_data", 64'(lane_data), 64'(0));
        chk("rst_ready", 64'(axi_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        channel_up = 1'b1;
        logging    = 1'b1;

        // 1: three-beat multi-lane frame with a partial last beat
        wait_cc_end();
        log_q.delete();
        push_beat(32'h1111_2222, 2'b11, 1'b0);
        push_beat(32'h3333_4444, 2'b11, 1'b0);
        push_beat(32'h0000_5555, 2'b01, 1'b1);
        send_queue();
        tick(4);
        exp_tok.delete();
        exp_tok.push_back(mk(OS_SCP, 16'h0, OS_IDLE, 16'h0));
        exp_tok.push_back(mk(OS_DATA, 16'h2222, OS_DATA, 16'h1111));
        exp_tok.push_back(mk(OS_DATA, 16'h4444, OS_DATA, 16'h3333));
        exp_tok.push_back(mk(OS_DATA, 16'h5555, OS_IDLE, 16'h0));
        exp_tok.push_back(mk(OS_ECP, 16'h0, OS_IDLE, 16'h0));
        exp_tok.push_back(mk(OS_IDLE, 16'h0, OS_IDLE, 16'h0));
        expect_seq("t1", base);
        chk("t1_ready", 64'({log_q[base].rdy, log_q[base+1].rdy, log_q[base+2].rdy, log_q[base+3].rdy}),
            64'(4'b1110));

        // 2: single-lane serialisation
        wait_cc_end();
        log_q.delete();
        single_lane = 1'b1;
        push_beat(32'hAAAA_BBBB, 2'b11, 1'b0);
        push_beat(32'hCCCC_DDDD, 2'b11, 1'b1);
        send_queue();
        tick(6);
        exp_tok.delete();
        exp_tok.push_back(mk(OS_SCP, 16'h0, OS_IDLE, 16'h0));
        exp_tok.push_back(mk(OS_DATA, 16'hBBBB, OS_IDLE, 16'h0));
        exp_tok.push_back(mk(OS_DATA, 16'hAAAA, OS_IDLE, 16'h0));
        exp_tok.push_back(mk(OS_DATA, 16'hDDDD, OS_IDLE, 16'h0));
        exp_tok.push_back(mk(OS_DATA, 16'hCCCC, OS_IDLE, 16'h0));
        exp_tok.push_back(mk(OS_ECP, 16'h0, OS_IDLE, 16'h0));
        exp_tok.push_back(mk(OS_IDLE, 16'h0, OS_IDLE, 16'h0));
        expect_seq("t2", base);
        chk("t2_ready", 64'({log_q[base].rdy, log_q[base+1].rdy, log_q[base+2].rdy, log_q[base+3].rdy}),
            64'(4'b1010));
        single_lane = 1'b0;

        // 3: continuous random traffic, multi-lane then single-lane
        wait_cc_end();
        log_q.delete();
        exp_words.delete();
        gen_frames(30);
        send_queue();
        tick(8);
        check_words("t3", 30, 1'b0);
        check_cc("t3");

        wait_cc_end();
        log_q.delete();
        exp_words.delete();
        single_lane = 1'b1;
        gen_frames(8);
        send_queue();
        tick(8);
        check_words("t3sl", 8, 1'b1);
        single_lane = 1'b0;

        // 4: channel drop mid-frame
        wait_cc_end();
        log_q.delete();
        send_beat(32'h0101_0202, 2'b11, 1'b0);
        send_beat(32'h0303_0404, 2'b11, 1'b0);
        axi_valid  = 1'b0;
        channel_up = 1'b0;
        tick(1);
        chk("t4_os0", 64'(lane_os[0]), 64'(OS_IDLE));
        chk("t4_os1", 64'(lane_os[1]), 64'(OS_IDLE));
        chk("t4_data", 64'(lane_data), 64'(0));
        chk("t4_ready", 64'(axi_ready), 64'(0));
        tick(3);
        base = 0;
        foreach (log_q[j]) if (log_q[j].os0 == OS_ECP) base++;
        chk("t4_no_ecp", 64'(base), 64'(0));
        channel_up = 1'b1;
        log_q.delete();
        tick(2);
        push_beat(32'h0505_0606, 2'b11, 1'b1);
        send_queue();
        tick(4);
        exp_tok.delete();
        exp_tok.push_back(mk(OS_SCP, 16'h0, OS_IDLE, 16'h0));
        exp_tok.push_back(mk(OS_DATA, 16'h0606, OS_DATA, 16'h0505));
        exp_tok.push_back(mk(OS_ECP, 16'h0, OS_IDLE, 16'h0));
        expect_seq("t4_resume", base);
        chk("t4_first_nonidle_is_scp", 64'(base == 0 || log_q[0].os0 == OS_IDLE), 64'(1));

        // 5: back-to-back frames
        wait_cc_end();
        log_q.delete();
        push_beat(32'h7777_8888, 2'b11, 1'b1);
        push_beat(32'h9999_AAAA, 2'b11, 1'b0);
        push_beat(32'hBBBB_CCCC, 2'b01, 1'b1);
        send_queue();
        tick(5);
        exp_tok.delete();
        exp_tok.push_back(mk(OS_SCP, 16'h0, OS_IDLE, 16'h0));
        exp_tok.push_back(mk(OS_DATA, 16'h8888, OS_DATA, 16'h7777));
        exp_tok.push_back(mk(OS_ECP, 16'h0, OS_IDLE, 16'h0));
        exp_tok.push_back(mk(OS_SCP, 16'h0, OS_IDLE, 16'h0));
        exp_tok.push_back(mk(OS_DATA, 16'hAAAA, OS_DATA, 16'h9999));
        exp_tok.push_back(mk(OS_DATA, 16'hCCCC, OS_IDLE, 16'h0));
        exp_tok.push_back(mk(OS_ECP, 16'h0, OS_IDLE, 16'h0));
        exp_tok.push_back(mk(OS_IDLE, 16'h0, OS_IDLE, 16'h0));
        expect_seq("t5", base);

        // 6: asynchronous reset while serialising
        wait_cc_end();
        single_lane = 1'b1;
        send_beat(32'h1234_5678, 2'b11, 1'b1);
        chk("t6_pre_os0", 64'(lane_os[0]), 64'(OS_DATA));
        chk("t6_pre_data", 64'(lane_data[15:0]), 64'(16'h5678));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_os0", 64'(lane_os[0]), 64'(OS_IDLE));
        chk("t6_rst_os1", 64'(lane_os[1]), 64'(OS_IDLE));
        chk("t6_rst_data", 64'(lane_data), 64'(0));
        chk("t6_rst_ready", 64'(axi_ready), 64'(0));
        axi_valid   = 1'b0;
        single_lane = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        log_q.delete();
        push_beat(32'hFEED_BEEF, 2'b11, 1'b1);
        send_queue();
        tick(4);
        exp_tok.delete();
        exp_tok.push_back(mk(OS_SCP, 16'h0, OS_IDLE, 16'h0));
        exp_tok.push_back(mk(OS_DATA, 16'hBEEF, OS_DATA, 16'hFEED));
        exp_tok.push_back(mk(OS_ECP, 16'h0, OS_IDLE, 16'h0));
        exp_tok.push_back(mk(OS_IDLE, 16'h0, OS_IDLE, 16'h0));
        expect_seq("t6_after", base);
        chk("t6_scp_first", 64'(log_q[0].os0 == OS_SCP || base > 0), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
